// File: rtl/mdu_iterative.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional macro MDU_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero finish after one cycle.
module mdu_iterative #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   prod_q, prod_d;
  logic [31:0]   opnd_q, opnd_d;
  logic [31:0]   a_raw_q, a_raw_d;
  logic          is_div_q, is_div_d;
  logic          neg_q, neg_d;
  logic          sign_a_q, sign_a_d;
  logic          div0_q, div0_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;

  logic          op_signed;
  logic [31:0]   a_mag, b_mag;
  logic [32:0]   add_sum;
  logic [63:0]   mult_next;
  logic [32:0]   rem_sh;
  logic          rem_ge;
  logic [31:0]   rem_sub;
  logic [63:0]   div_next;
  logic [63:0]   prod_neg;

  // Magnitudes are taken as unsigned, so -2^31 maps cleanly onto 32'h8000_0000.
  assign op_signed = ~op[0];
  assign a_mag     = (op_signed && a[31]) ? -a : a;
  assign b_mag     = (op_signed && b[31]) ? -b : b;

  // Multiply: prod holds {partial sum, remaining multiplier bits}.
  assign add_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mult_next = {add_sum, prod_q[31:1]};

  // Divide: prod holds {remainder, dividend/quotient}; shifted remainder can be 33 bits wide.
  assign rem_sh    = prod_q[63:31];
  assign rem_ge    = rem_sh >= {1'b0, opnd_q};
  assign rem_sub   = prod_q[62:31] - opnd_q;
  assign div_next  = rem_ge ? {rem_sub, prod_q[30:0], 1'b1} : {prod_q[62:0], 1'b0};

  assign prod_neg  = -prod_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !op[2]) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          sign_a_d = op_signed & a[31];
          neg_d    = op_signed & (a[31] ^ b[31]);
          a_raw_d  = a;
          div0_d   = op[1] & (b == 32'd0);
          if (op[1]) begin
            prod_d = {32'd0, a_mag};
            opnd_d = b_mag;
          end else begin
            prod_d = {32'd0, b_mag};
            opnd_d = a_mag;
          end
`ifdef MDU_EARLY_OUT_EN
          if (op[1] ? (b == 32'd0) : (a == 32'd0 || b == 32'd0)) begin
            state_d = FINISH;
            if (!op[1]) prod_d = 64'd0;
          end
`else
`endif
        end else if (start && op[2] && !op[1]) begin
          if (op[0]) lo_d = a;
          else       hi_d = a;
        end
      end

      CALC: begin
        prod_d = is_div_q ? div_next : mult_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = FINISH;
      end

      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            lo_d = neg_q    ? -prod_q[31:0]  : prod_q[31:0];
            hi_d = sign_a_q ? -prod_q[63:32] : prod_q[63:32];
          end
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed, table-driven bench for mdu_iterative: result values, latency, hold and boundary cases.
module tb_mdu_iterative;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;

  mdu_iterative dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input vec_t v);
    int lat;
    lat = 33;
`ifdef MDU_EARLY_OUT_EN
    if (v.op[1] ? (v.b == 32'd0) : (v.a == 32'd0 || v.b == 32'd0)) lat = 1;
`endif
    return lat;
  endfunction

  // Issue one mult/div, scramble operands after the sampling edge, then track busy/done/HI/LO.
  task automatic run_op(input vec_t v, input string tag);
    logic [31:0] hi0, lo0;
    bit          held;
    int          cyc;
    @(negedge clk);
    hi0   = hi;
    lo0   = lo;
    start = 1'b1;
    op    = v.op;
    a     = v.a;
    b     = v.b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    check({tag, "_busy_rise"}, busy, 1);
    held = 1'b1;
    cyc  = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done && (!busy || hi !== hi0 || lo !== lo0)) held = 1'b0;
    end
    check({tag, "_latency"}, cyc, exp_latency(v));
    check({tag, "_hold"}, held, 1);
    check({tag, "_hi"}, hi, v.hi);
    check({tag, "_lo"}, lo, v.lo);
    check({tag, "_busy_fall"}, busy, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    $display("%s op=%b a=%h b=%h -> hi=%h lo=%h after %0d cycles", tag, v.op, v.a, v.b, hi, lo, cyc);
  endtask

  task automatic move_to(input logic [2:0] mop, input logic [31:0] val);
    @(negedge clk);
    start = 1'b1;
    op    = mop;
    a     = val;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hi0, lo0;
    int          cyc;
    vec_t        v;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[5]  = '{OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[11] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};

    rst   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    @(negedge clk);
    rst = 1'b0;

    move_to(OP_MTHI, 32'hDEAD_BEEF);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo", lo, 0);
    check("mthi_busy", busy, 0);
    check("mthi_done", done, 0);
    $display("mthi: hi=%h lo=%h busy=%b", hi, lo, busy);
    move_to(OP_MTLO, 32'h0BAD_F00D);
    check("mtlo_lo", lo, 32'h0BAD_F00D);
    check("mtlo_hi", hi, 32'hDEAD_BEEF);
    $display("mtlo: hi=%h lo=%h busy=%b", hi, lo, busy);

    move_to(OP_NOP, 32'h1111_1111);
    check("nop_busy", busy, 0);
    check("nop_hi", hi, 32'hDEAD_BEEF);
    check("nop_lo", lo, 32'h0BAD_F00D);
    $display("nop: hi=%h lo=%h busy=%b", hi, lo, busy);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // MTLO arriving mid-multiply must be dropped.
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd3;
    b     = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi0   = hi;
    lo0   = lo;
    repeat (5) @(posedge clk);
    move_to(OP_MTLO, 32'hAAAA_5555);
    check("busy_mtlo_lo_held", lo, lo0);
    check("busy_mtlo_hi_held", hi, hi0);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("busy_mtlo_done_seen", done, 1);
    check("busy_mtlo_lo", lo, 32'd12);
    check("busy_mtlo_hi", hi, 32'd0);
    $display("mtlo while busy: hi=%h lo=%h", hi, lo);

    // Reset ten edges into a multiply aborts it and clears HI/LO immediately.
    move_to(OP_MTHI, 32'hCAFE_0001);
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'hFFFF_FFFD;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    $display("abort: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    @(negedge clk);
    rst = 1'b0;

    v = '{OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30};
    run_op(v, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
